muldiv_unit: RTL and testbench

- Iterative, parametrised RV32M multiply/divide unit.
- Sits in the Execute stage beside the ALU and replaces the current shift-add multiplier.
- Runs on the single system clock, so there is no separate multiplier clock domain and no metastability crossing.
- Implements all eight M-extension ops with RISC-V divide-by-zero and overflow semantics. A start/busy/done handshake lets the pipeline control stall Execute.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      CALC = 2'd2,
      FIX  = 2'd3
   } state_t;

   // Divide family (DIV, DIVU, REM, REMU)
   function automatic logic is_div(input logic [2:0] f);
      return f[2];
   endfunction

   // rs1 is interpreted as a signed value
   function automatic logic is_signed_a(input logic [2:0] f);
      return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
   endfunction

   // rs2 is interpreted as a signed value
   function automatic logic is_signed_b(input logic [2:0] f);
      return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
   endfunction

   // Result comes from the upper half of the shift register (MULH*, REM*)
   function automatic logic hi_half(input logic [2:0] f);
      return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_MULHU) ||
             (f == OP_REM)  || (f == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with start/busy/done handshake.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
)(
   input  logic             CLK,
   input  logic             Reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned AW    = WIDTH + 2;

   state_t                 state, state_nxt;
   logic [2:0]             op_r, op_nxt;
   logic [2*WIDTH-1:0]     acc, acc_nxt;
   logic [WIDTH-1:0]       opnd, opnd_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   sign, sign_nxt;
   logic                   busy_nxt, done_nxt;
   logic [WIDTH-1:0]       result_nxt;

   logic                   div_op;
   logic [WIDTH:0]         add_x, add_y;
   logic [AW-1:0]          add_s;
   logic [WIDTH-1:0]       a_in, b_in, mag_a, mag_b;
   logic                   a_neg, b_neg, div_zero, div_ovf;
   logic [2*WIDTH-1:0]     full;
   logic [WIDTH-1:0]       half;

   assign div_op = is_div(op_r);

   // Shared adder/subtractor: add multiplicand for MUL, trial-subtract divisor for DIV
   always_comb begin
      add_x = div_op ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_y = div_op ? ~{1'b0, opnd} : {1'b0, opnd};
      add_s = AW'(add_x) + AW'(add_y) + AW'(div_op);
   end

   // Operand magnitudes and special-case detection; raw a sits in acc low, raw b in opnd
   always_comb begin
      a_in     = acc[WIDTH-1:0];
      b_in     = opnd;
      a_neg    = is_signed_a(op_r) & a_in[WIDTH-1];
      b_neg    = is_signed_b(op_r) & b_in[WIDTH-1];
      mag_a    = a_neg ? -a_in : a_in;
      mag_b    = b_neg ? -b_in : b_in;
      div_zero = div_op && (b_in == '0);
      div_ovf  = ((op_r == OP_DIV) || (op_r == OP_REM)) &&
                 (a_in == {1'b1, {(WIDTH-1){1'b0}}}) && (b_in == '1);
   end

   // Sign fix-up and half selection for the final result
   always_comb begin
      full = (!div_op && sign) ? -acc : acc;
      half = hi_half(op_r) ? full[2*WIDTH-1:WIDTH] : full[WIDTH-1:0];
      if (div_op && sign) begin
         half = -half;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt  = state;
      op_nxt     = op_r;
      acc_nxt    = acc;
      opnd_nxt   = opnd;
      cnt_nxt    = cnt;
      sign_nxt   = sign;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      result_nxt = result;
      case (state)
         IDLE: begin
            if (start) begin
               op_nxt    = op;
               acc_nxt   = {{WIDTH{1'b0}}, a};
               opnd_nxt  = b;
               busy_nxt  = 1'b1;
               state_nxt = PREP;
            end
         end
         PREP: begin
            cnt_nxt = CNT_W'(WIDTH);
            if (div_zero) begin
               // quotient all ones, remainder = dividend
               acc_nxt   = {a_in, {WIDTH{1'b1}}};
               sign_nxt  = 1'b0;
               state_nxt = FIX;
            end else if (div_ovf) begin
               acc_nxt   = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
               sign_nxt  = 1'b0;
               state_nxt = FIX;
            end else begin
               sign_nxt  = (div_op && hi_half(op_r)) ? a_neg : (a_neg ^ b_neg);
               acc_nxt   = {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
               opnd_nxt  = div_op ? mag_b : mag_a;
               state_nxt = CALC;
            end
         end
         CALC: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (div_op) begin
               if (add_s[WIDTH+1]) begin
                  acc_nxt = {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               end else begin
                  acc_nxt = {add_x[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               end
            end else begin
               if (acc[0]) begin
                  acc_nxt = {add_s[WIDTH:0], acc[WIDTH-1:1]};
               end else begin
                  acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
               end
            end
            if (cnt == CNT_W'(1)) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            result_nxt = half;
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state  <= IDLE;
         op_r   <= '0;
         acc    <= '0;
         opnd   <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         op_r   <= op_nxt;
         acc    <= acc_nxt;
         opnd   <= opnd_nxt;
         cnt    <= cnt_nxt;
         sign   <= sign_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         result <= result_nxt;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8 instances).
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start32, busy32, done32;
   logic [2:0]  op32;
   logic [31:0] a32, b32, result32;
   logic        start8, busy8, done8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, result8;

   int n_chk;
   int n_fail;

   muldiv_unit #(.WIDTH(32)) u32 (
      .CLK(clk), .Reset(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .result(result32)
   );

   muldiv_unit #(.WIDTH(8)) u8 (
      .CLK(clk), .Reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op on the 32-bit unit; returns in the done cycle (busy=0)
   task automatic do_op32(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
      int   lat;
      logic busy_ok;
      op32 = o; a32 = x; b32 = y; start32 = 1'b1;
      step();
      start32 = 1'b0;
      a32 = ~x; b32 = ~y; op32 = ~o;
      lat = 0;
      busy_ok = 1'b1;
      while (done32 !== 1'b1 && lat < 100) begin
         if (busy32 !== 1'b1) busy_ok = 1'b0;
         step();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, result32, exp);
      check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
      check({tag, " busy low at done"}, {31'd0, busy32}, 32'd0);
   endtask

   task automatic do_op8(input string tag, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] exp, input int exp_lat);
      int lat;
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      step();
      start8 = 1'b0;
      lat = 0;
      while (done8 !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, {24'd0, result8}, {24'd0, exp});
   endtask

   initial begin
      int lat;
      int dones;
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      step();
      step();
      check("reset busy", {31'd0, busy32}, 32'd0);
      check("reset done", {31'd0, done32}, 32'd0);
      check("reset result", result32, 32'd0);
      rst_n = 1'b1;
      step();

      // Multiply low half, then confirm single-cycle done and held result
      do_op32("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      step();
      check("MUL done pulse width", {31'd0, done32}, 32'd0);
      check("MUL result hold", result32, 32'hFFFF_FFEB);

      // High-half multiplies
      do_op32("MULH", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      do_op32("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      do_op32("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
      step();

      // Divides issued back to back from each done cycle
      do_op32("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      do_op32("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      do_op32("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
      do_op32("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

      // Divide-by-zero and signed overflow shortcuts
      do_op32("DIV 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
      do_op32("REMU 5/0", OP_REMU, 32'd5, 32'd0, 32'd5, 2);
      do_op32("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
      do_op32("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
      step();

      // start during busy is ignored
      op32 = OP_MULHU; a32 = 32'h0001_0000; b32 = 32'h0003_0000; start32 = 1'b1;
      step();
      start32 = 1'b0;
      lat = 0;
      repeat (4) begin
         step();
         lat++;
      end
      op32 = OP_MUL; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
      step();
      lat++;
      start32 = 1'b0;
      while (done32 !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      check("ignored start latency", 32'(lat), 32'd34);
      check("ignored start result", result32, 32'd3);
      dones = 0;
      repeat (40) begin
         step();
         if (done32 === 1'b1) dones++;
      end
      check("ignored start no extra done", 32'(dones), 32'd0);
      check("ignored start busy idle", {31'd0, busy32}, 32'd0);

      // Reset in the middle of a multiply
      op32 = OP_MUL; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
      step();
      start32 = 1'b0;
      repeat (9) step();
      rst_n = 1'b0;
      step();
      check("abort busy", {31'd0, busy32}, 32'd0);
      check("abort result", result32, 32'd0);
      check("abort done", {31'd0, done32}, 32'd0);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         step();
         if (done32 === 1'b1) dones++;
      end
      check("abort no done", 32'(dones), 32'd0);

      // 8-bit instance
      do_op8("W8 MULHU", OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 10);
      do_op8("W8 DIV ovf", OP_DIV, 8'h80, 8'hFF, 8'h80, 2);
      do_op8("W8 DIVU 200/7", OP_DIVU, 8'd200, 8'd7, 8'd28, 10);
      do_op8("W8 REM -100/7", OP_REM, 8'h9C, 8'd7, 8'hFE, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
